// File: rtl/instr_fetch.sv
// instr_fetch: single-stage instruction fetch unit with a one-entry output
// register toward decode.
//
// Instruction memory is read asynchronously: Address is the registered PC and
// Instruction returns the word for it in the same cycle. Each load cycle
// captures that word into the output register and advances the PC by 4.
// A redirect from execute flushes the output register and reloads the PC,
// which gives a single bubble cycle. A word of all ones is a halt: it is
// delivered normally, then the unit stops fetching until reset.
//
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN
//   defined   - a redirect whose target has nonzero low bits pulses
//               Fetch_error, flushes the output and halts with the PC unchanged.
//   undefined - the low two target bits are dropped and Fetch_error stays 0.
//
// Ports
//   Clk           in   clock, rising edge
//   Rst_n         in   synchronous active-low reset
//   Address       out  fetch address (current PC)
//   Instruction   in   memory read data for Address
//   Branch_taken  in   redirect request
//   Branch_target in   redirect address
//   Out_valid     out  Out_instr/Out_pc hold a fetched instruction
//   Out_ready     in   decode accepts the held instruction this cycle
//   Out_instr     out  fetched instruction word
//   Out_pc        out  address Out_instr came from
//   Halted        out  unit is in HALT
//   Fetch_error   out  one-cycle misaligned-redirect pulse
//
// States
//   state | meaning
//   FETCH | loading one word per cycle whenever the output slot is free
//   HALT  | halt word or misaligned redirect seen; no loads, redirects ignored

module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Branch_taken,
  input  logic [ADDR_W-1:0]  Branch_target,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [INSTR_W-1:0] Out_instr,
  output logic [ADDR_W-1:0]  Out_pc,
  output logic               Halted,
  output logic               Fetch_error
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  out_pc_nxt;
  logic [INSTR_W-1:0] out_instr_nxt;
  logic               out_valid_nxt;
  logic               fetch_error_nxt;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      Out_valid   <= 1'b0;
      Out_instr   <= '0;
      Out_pc      <= '0;
      Fetch_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      Out_valid   <= out_valid_nxt;
      Out_instr   <= out_instr_nxt;
      Out_pc      <= out_pc_nxt;
      Fetch_error <= fetch_error_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    out_valid_nxt   = Out_valid;
    out_instr_nxt   = Out_instr;
    out_pc_nxt      = Out_pc;
    fetch_error_nxt = 1'b0;

    case (state)
      FETCH: begin
        if (Branch_taken) begin
          // Redirect wins over load and stall; the word on Instruction and
          // any held word are both dropped.
          out_valid_nxt = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
          if (Branch_target[1:0] != 2'b00) begin
            fetch_error_nxt = 1'b1;
            state_nxt       = HALT;
          end else begin
            pc_nxt = Branch_target;
          end
`else
          pc_nxt = Branch_target & ~ADDR_W'(3);
`endif
        end else if (!Out_valid || Out_ready) begin
          out_instr_nxt = Instruction;
          out_pc_nxt    = pc;
          out_valid_nxt = 1'b1;
          // Halt word: PC stays parked on the halt address.
          if (&Instruction) state_nxt = HALT;
          else              pc_nxt    = pc + ADDR_W'(4);
        end
      end
      HALT: begin
        if (Out_valid && Out_ready) out_valid_nxt = 1'b0;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign Address = pc;
  assign Halted  = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run.
// The reference model is a stream of expected (pc, word) pairs: after reset or
// a redirect to T, decode must see mem(T), mem(T+4), ... in order, ending after
// a halt word. A monitor pops one entry per decode handshake.

module tb_instr_fetch;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] Out_instr;
  logic [31:0] Out_pc;
  logic        Halted;
  logic        Fetch_error;

  instr_fetch dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Address      (Address),
    .Instruction  (Instruction),
    .Branch_taken (Branch_taken),
    .Branch_target(Branch_target),
    .Out_valid    (Out_valid),
    .Out_ready    (Out_ready),
    .Out_instr    (Out_instr),
    .Out_pc       (Out_pc),
    .Halted       (Halted),
    .Fetch_error  (Fetch_error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // memory contents
  bit          pat_mode;   // 0: 0x11*(index+1), 1: scrambled
  bit          halt_en;
  logic [31:0] halt_addr;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    logic [31:0] d;
    d = (a * 32'h9E3779B1) ^ 32'h5A5A1234 ^ (a >> 7);
    if (d == 32'hFFFF_FFFF) d = 32'h0;
    return d;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit pm,
                                           input bit he, input logic [31:0] ha);
    if (he && a == ha) return 32'hFFFF_FFFF;
    if (pm) return hashw(a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  assign Instruction = mem_word(Address, pat_mode, halt_en, halt_addr);

  // scoreboard
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] np;
  bit          stream_stop;
  bit          model_halted;
  int          checks;
  int          errors;
  int          hs_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void top_up();
    exp_t e;
    while (!stream_stop && q.size() < 4) begin
      e.pc    = np;
      e.instr = mem_word(np, pat_mode, halt_en, halt_addr);
      q.push_back(e);
      if (e.instr == 32'hFFFF_FFFF) stream_stop = 1'b1;
      np = np + 32'd4;
    end
  endfunction

  always @(negedge Clk) begin
    if (Rst_n && Out_valid && Out_ready) begin
      checks++;
      hs_count++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual pc=%h instr=%h required none", Out_pc, Out_instr);
      end else begin
        mon_e = q.pop_front();
        if (Out_pc !== mon_e.pc || Out_instr !== mon_e.instr) begin
          errors++;
          $display("FAIL sb_word actual pc=%h instr=%h required pc=%h instr=%h",
                   Out_pc, Out_instr, mon_e.pc, mon_e.instr);
        end
        if (mon_e.instr == 32'hFFFF_FFFF) model_halted = 1'b1;
      end
    end
  end

  // Called at posedge+1: drive one cycle of inputs, advance the model after
  // the edge, and return at the next posedge+1.
  task automatic step(input bit br, input logic [31:0] tgt, input bit rdy);
    Branch_taken  = br;
    Branch_target = tgt;
    Out_ready     = rdy;
    @(posedge Clk);
    if (br && !model_halted) begin
      q.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        model_halted = 1'b1;
        stream_stop  = 1'b1;
      end else begin
        np          = tgt;
        stream_stop = 1'b0;
      end
`else
      np          = {tgt[31:2], 2'b00};
      stream_stop = 1'b0;
`endif
    end
    top_up();
    #1;
  endtask

  task automatic do_reset();
    Rst_n         = 1'b0;
    Branch_taken  = 1'b0;
    Branch_target = 32'h0;
    Out_ready     = 1'b1;
    repeat (2) @(posedge Clk);
    q.delete();
    np           = 32'h0;
    stream_stop  = 1'b0;
    model_halted = 1'b0;
    top_up();
    #1;
    Rst_n = 1'b1;
    chk("rst_addr", Address, 32'h0);
    chk("rst_valid", Out_valid, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_ferr", Fetch_error, 0);
    chk("rst_out_pc", Out_pc, 32'h0);
  endtask

  logic [31:0] a0;
  int          hs0;
  bit          rbr;
  bit          rrdy;
  logic [31:0] rtgt;

  initial begin
    checks = 0; errors = 0; hs_count = 0;
    Rst_n = 1'b0; Branch_taken = 1'b0; Branch_target = 32'h0; Out_ready = 1'b1;
    pat_mode = 1'b0; halt_en = 1'b0; halt_addr = 32'h0;
    q.delete(); np = 32'h0; stream_stop = 1'b0; model_halted = 1'b0;
    @(posedge Clk); #1;

    // reset release and streaming
    do_reset();
    step(0, 32'h0, 1);
    chk("first_valid", Out_valid, 1);
    chk("first_pc", Out_pc, 32'h0);
    chk("first_instr", Out_instr, 32'h11);
    chk("first_addr", Address, 32'h4);
    step(0, 32'h0, 1);
    chk("second_pc", Out_pc, 32'h4);
    chk("second_instr", Out_instr, 32'h22);

    // stall holds everything
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 0);
      chk("stall_addr", Address, 32'h8);
      chk("stall_instr", Out_instr, 32'h22);
      chk("stall_pc", Out_pc, 32'h4);
      chk("stall_valid", Out_valid, 1);
    end
    step(0, 32'h0, 1);
    chk("unstall_pc", Out_pc, 32'h8);
    chk("unstall_instr", Out_instr, 32'h33);

    // redirect during a stall
    step(0, 32'h0, 0);
    step(1, 32'h100, 0);
    chk("br_bubble_valid", Out_valid, 0);
    chk("br_addr", Address, 32'h100);
    step(0, 32'h0, 1);
    chk("br_valid", Out_valid, 1);
    chk("br_pc", Out_pc, 32'h100);
    chk("br_instr", Out_instr, 32'h451);

    // wrap
    step(1, 32'hFFFF_FFF8, 1);
    step(0, 32'h0, 1);
    step(0, 32'h0, 1);
    chk("wrap_pc", Out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", Address, 32'h0);

    // misaligned redirect
    a0 = Address;
    step(1, 32'h102, 1);
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("mis_ferr", Fetch_error, 1);
    chk("mis_halted", Halted, 1);
    chk("mis_valid", Out_valid, 0);
    chk("mis_addr", Address, a0);
    step(0, 32'h0, 1);
    chk("mis_ferr_pulse", Fetch_error, 0);
    chk("mis_halted_hold", Halted, 1);
    do_reset();
`else
    chk("mis_ferr", Fetch_error, 0);
    chk("mis_addr", Address, 32'h100);
    step(0, 32'h0, 1);
    chk("mis_pc", Out_pc, 32'h100);
    chk("mis_ferr_hold", Fetch_error, 0);
    chk("mis_halted", Halted, 0);
`endif

    // halt word at 0xC
    halt_en = 1'b1; halt_addr = 32'hC;
    do_reset();
    repeat (4) step(0, 32'h0, 1);
    chk("halt_instr", Out_instr, 32'hFFFF_FFFF);
    chk("halt_pc", Out_pc, 32'hC);
    chk("halt_flag", Halted, 1);
    chk("halt_addr", Address, 32'hC);
    step(1, 32'h40, 1);
    chk("halt_br_ignored_addr", Address, 32'hC);
    chk("halt_br_halted", Halted, 1);
    chk("halt_valid_clear", Out_valid, 0);
    repeat (2) begin
      step(0, 32'h0, 1);
      chk("halt_no_load", Out_valid, 0);
    end
    halt_en = 1'b0;
    do_reset();

    // redirect coinciding with a halt word
    halt_en = 1'b1; halt_addr = 32'h8;
    do_reset();
    repeat (2) step(0, 32'h0, 1);
    chk("coin_addr_pre", Address, 32'h8);
    step(1, 32'h200, 1);
    chk("coin_halted", Halted, 0);
    chk("coin_addr", Address, 32'h200);
    step(0, 32'h0, 1);
    chk("coin_pc", Out_pc, 32'h200);
    chk("coin_valid", Out_valid, 1);
    halt_en = 1'b0;

    // randomized run
    pat_mode = 1'b1;
    do_reset();
    hs0 = hs_count;
    for (int i = 0; i < 3000; i++) begin
      rbr  = ($urandom_range(0, 9) == 0);
      rtgt = $urandom;
`ifdef IFETCH_MISALIGN_CHECK_EN
      rtgt[1:0] = 2'b00;
`endif
      rrdy = ($urandom_range(0, 9) < 7);
      step(rbr, rtgt, rrdy);
      chk("rand_flags", {30'h0, Halted, Fetch_error}, 32'h0);
    end
    chk("rand_progress", (hs_count - hs0) > 500, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
